convenc: RTL and testbench



---
 rtl/convenc.sv | 87 ++++++++
 tb/tb_convenc.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/convenc.sv
// convenc: rate-1/2 feed-forward convolutional encoder, constraint length 4.
// Each accepted input bit produces one registered coded pair (v1, v2) with
// valid_out, one clock later. The 3-bit history register can be preset from
// seed. With TAIL=1 the encoder appends three zero-input flush symbols when
// the input burst ends, which returns the history to 000.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears history, outputs and flush
//   data       serial information bit, used only when valid_in=1
//   valid_in   qualifies data for the current cycle
//   load       synchronous preset of the history register from seed
//   seed[2:0]  preset value for s[2:0]
//   v1, v2     registered coded bits from G1 and G2
//   valid_out  high for one cycle per emitted coded pair
module convenc #(
   parameter logic [3:0] G1   = 4'b1101,
   parameter logic [3:0] G2   = 4'b1111,
   parameter bit         TAIL = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data,
   input  logic       valid_in,
   input  logic       load,
   input  logic [2:0] seed,
   output logic       v1,
   output logic       v2,
   output logic       valid_out
);

   // s[2] is the most recent input bit, s[0] the oldest.
   logic [2:0] s;
   // Flush symbols still to send after the current one.
   logic [1:0] tail_cnt;
   logic       prev_valid;

   logic       d_enc;
   logic [3:0] u;
   logic       flush;

   always_comb begin
      flush = 1'b0;
      if (TAIL && (prev_valid || (tail_cnt != 2'd0)))
         flush = 1'b1;
      // Gate data so that an unknown value on an idle cycle never reaches
      // the tap vector; flush cycles also encode a zero.
      d_enc = valid_in & data;
      u     = {d_enc, s};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s          <= 3'b000;
         v1         <= 1'b0;
         v2         <= 1'b0;
         valid_out  <= 1'b0;
         tail_cnt   <= 2'd0;
         prev_valid <= 1'b0;
      end else if (load) begin
         // Same-cycle valid_in is discarded and cannot trigger a flush.
         s          <= seed;
         valid_out  <= 1'b0;
         tail_cnt   <= 2'd0;
         prev_valid <= 1'b0;
      end else if (valid_in) begin
         v1         <= ^(G1 & u);
         v2         <= ^(G2 & u);
         valid_out  <= 1'b1;
         s          <= {d_enc, s[2:1]};
         tail_cnt   <= 2'd0;
         prev_valid <= 1'b1;
      end else if (flush) begin
         v1         <= ^(G1 & u);
         v2         <= ^(G2 & u);
         valid_out  <= 1'b1;
         s          <= {1'b0, s[2:1]};
         // First flush symbol goes out now; two more follow.
         tail_cnt   <= prev_valid ? 2'd2 : (tail_cnt - 2'd1);
         prev_valid <= 1'b0;
      end else begin
         valid_out  <= 1'b0;
         prev_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_convenc.sv
// tb_convenc: self-checking bench for convenc. Two instances share inputs:
// dut0 with TAIL=0 and dut1 with TAIL=1. A behavioural model keeps the last
// three input bits per instance and computes coded bits as generator parities.
module tb_convenc;

   logic       clk;
   logic       reset;
   logic       data;
   logic       valid_in;
   logic       load;
   logic [2:0] seed;
   logic       v1_0, v2_0, vo_0;
   logic       v1_1, v2_1, vo_1;

   localparam logic [3:0] GEN1 = 4'b1101;
   localparam logic [3:0] GEN2 = 4'b1111;

   convenc #(.G1(GEN1), .G2(GEN2), .TAIL(1'b0)) dut0 (
      .clk(clk), .reset(reset), .data(data), .valid_in(valid_in),
      .load(load), .seed(seed), .v1(v1_0), .v2(v2_0), .valid_out(vo_0)
   );

   convenc #(.G1(GEN1), .G2(GEN2), .TAIL(1'b1)) dut1 (
      .clk(clk), .reset(reset), .data(data), .valid_in(valid_in),
      .load(load), .seed(seed), .v1(v1_1), .v2(v2_1), .valid_out(vo_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // hist[i][k] = input bit (k+1) symbols ago for instance i
   int hist [2][3];
   int flush_left [2];
   bit pv [2];
   bit ev1 [2];
   bit ev2 [2];
   bit evo [2];

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic enc(input int i, input int d);
      int taps [4];
      int p1, p2;
      taps[3] = d;
      taps[2] = hist[i][0];
      taps[1] = hist[i][1];
      taps[0] = hist[i][2];
      p1 = 0;
      p2 = 0;
      for (int k = 0; k < 4; k++) begin
         if (GEN1[k]) p1 += taps[k];
         if (GEN2[k]) p2 += taps[k];
      end
      ev1[i] = bit'(p1 % 2);
      ev2[i] = bit'(p2 % 2);
      evo[i] = 1'b1;
      hist[i][2] = hist[i][1];
      hist[i][1] = hist[i][0];
      hist[i][0] = d;
   endtask

   task automatic model_step(input int i, input bit tail, input bit r,
                             input bit l, input logic [2:0] sd,
                             input bit vi, input bit d);
      if (r) begin
         for (int k = 0; k < 3; k++) hist[i][k] = 0;
         flush_left[i] = 0;
         pv[i]  = 1'b0;
         ev1[i] = 1'b0;
         ev2[i] = 1'b0;
         evo[i] = 1'b0;
      end else if (l) begin
         hist[i][0] = int'(sd[2]);
         hist[i][1] = int'(sd[1]);
         hist[i][2] = int'(sd[0]);
         evo[i] = 1'b0;
         flush_left[i] = 0;
         pv[i] = 1'b0;
      end else if (vi) begin
         enc(i, int'(d));
         flush_left[i] = 0;
         pv[i] = 1'b1;
      end else begin
         if (tail && pv[i]) flush_left[i] = 3;
         pv[i] = 1'b0;
         if (flush_left[i] > 0) begin
            enc(i, 0);
            flush_left[i]--;
         end else begin
            evo[i] = 1'b0;
         end
      end
   endtask

   function automatic int exp_state(input int i);
      return hist[i][0] * 4 + hist[i][1] * 2 + hist[i][2];
   endfunction

   task automatic cycle(input bit r, input bit l, input logic [2:0] sd,
                        input bit vi, input bit d);
      reset    = r;
      load     = l;
      seed     = sd;
      valid_in = vi;
      data     = d;
      @(posedge clk);
      model_step(0, 1'b0, r, l, sd, vi, d);
      model_step(1, 1'b1, r, l, sd, vi, d);
      #1;
      chk("t0_v1", int'(v1_0), int'(ev1[0]));
      chk("t0_v2", int'(v2_0), int'(ev2[0]));
      chk("t0_vo", int'(vo_0), int'(evo[0]));
      chk("t0_s",  int'(dut0.s), exp_state(0));
      chk("t1_v1", int'(v1_1), int'(ev1[1]));
      chk("t1_v2", int'(v2_1), int'(ev2[1]));
      chk("t1_vo", int'(vo_1), int'(evo[1]));
      chk("t1_s",  int'(dut1.s), exp_state(1));
   endtask

   initial begin
      int pairs [4];
      int bits [4];
      int pulses;
      pairs = '{3, 3, 2, 3};
      bits  = '{1, 0, 1, 1};
      reset = 1'b1; load = 1'b0; seed = 3'b000; valid_in = 1'b0; data = 1'b0;
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 3; k++) hist[i][k] = 0;
         flush_left[i] = 0; pv[i] = 0; ev1[i] = 0; ev2[i] = 0; evo[i] = 0;
      end

      // reset then idle
      cycle(1, 0, 3'b000, 0, 0);
      cycle(1, 0, 3'b000, 0, 0);
      cycle(0, 0, 3'b000, 0, 0);
      chk("rst_pair", int'({v1_0, v2_0}), 0);
      chk("rst_vo",   int'(vo_0), 0);
      chk("rst_s",    int'(dut0.s), 0);

      // 1,0,1,1 from zero state
      for (int n = 0; n < 4; n++) begin
         cycle(0, 0, 3'b000, 1, bit'(bits[n]));
         chk("enc_pair0", int'({v1_0, v2_0}), pairs[n]);
         chk("enc_pair1", int'({v1_1, v2_1}), pairs[n]);
         chk("enc_vo",    int'(vo_0), 1);
      end
      chk("enc_s", int'(dut0.s), 6);

      // tail flush on dut1, state retention on dut0
      pairs = '{2, 2, 3, 0};
      for (int n = 0; n < 3; n++) begin
         cycle(0, 0, 3'b000, 0, 0);
         chk("tail_pair", int'({v1_1, v2_1}), pairs[n]);
         chk("tail_vo",   int'(vo_1), 1);
         chk("notail_vo", int'(vo_0), 0);
      end
      cycle(0, 0, 3'b000, 0, 0);
      chk("tail_end_vo", int'(vo_1), 0);
      chk("tail_end_s",  int'(dut1.s), 0);
      chk("notail_s",    int'(dut0.s), 6);
      cycle(0, 0, 3'b000, 0, 0);

      // seed load then encode a zero
      cycle(0, 1, 3'b111, 0, 0);
      chk("load_vo", int'(vo_0), 0);
      cycle(0, 0, 3'b000, 1, 0);
      chk("seed_pair", int'({v1_0, v2_0}), 1);
      chk("seed_s",    int'(dut0.s), 3);
      for (int n = 0; n < 4; n++) cycle(0, 0, 3'b000, 0, 0);

      // load and valid_in together: input discarded
      cycle(0, 1, 3'b010, 1, 1);
      chk("ldv_vo", int'(vo_0), 0);
      chk("ldv_s",  int'(dut0.s), 2);
      cycle(0, 0, 3'b000, 0, 0);
      chk("ldv_noflush", int'(vo_1), 0);

      // mid-stream reset, then resend
      pairs = '{3, 3, 2, 3};
      cycle(1, 0, 3'b000, 0, 0);
      cycle(0, 0, 3'b000, 1, 1);
      cycle(0, 0, 3'b000, 1, 0);
      cycle(1, 0, 3'b000, 1, 1);
      chk("mrst_pair", int'({v1_0, v2_0}), 0);
      chk("mrst_vo",   int'(vo_1), 0);
      for (int n = 0; n < 4; n++) begin
         cycle(0, 0, 3'b000, 1, bit'(bits[n]));
         chk("resend_pair", int'({v1_0, v2_0}), pairs[n]);
      end

      // 40-bit burst
      cycle(1, 0, 3'b000, 0, 0);
      pulses = 0;
      for (int n = 0; n < 40; n++) begin
         cycle(0, 0, 3'b000, 1, bit'($urandom_range(0, 1)));
         if (vo_0) pulses++;
      end
      chk("burst_pulses", pulses, 40);
      cycle(0, 0, 3'b000, 0, bit'($urandom_range(0, 1)));
      chk("burst_drop", int'(vo_0), 0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         bit r, l, vi;
         r  = ($urandom_range(0, 99) < 2);
         l  = ($urandom_range(0, 99) < 5);
         vi = ($urandom_range(0, 99) < 65);
         cycle(r, l, 3'($urandom_range(0, 7)), vi, bit'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
